// File: rtl/itr_trigger_gen.sv
// Address-triggered interrupt stimulus generator: a programmable table of one-shot
// address triggers, each driving one interrupt channel as a fixed pulse or a held level.
module itr_trigger_gen #(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 16,
  parameter int CHANNELS = 6,
  parameter int LEN_W    = 8,
  parameter int IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_mode,
  input  logic                  cfg_valid,
  input  logic                  rearm,
  input  logic [CHANNELS-1:0]   ack,
  output logic [CHANNELS-1:0]   irq,
  output logic [ENTRIES-1:0]    fired,
  output logic                  busy,
  output logic [2*CHANNELS-1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } ch_state_e;

  // Trigger table; only valid and fired need a reset value.
  logic [ENTRIES-1:0] e_valid;
  logic [ADDR_W-1:0]  e_addr [ENTRIES];
  logic [CH_W-1:0]    e_chan [ENTRIES];
  logic [LEN_W-1:0]   e_len  [ENTRIES];
  logic [ENTRIES-1:0] e_mode;

  ch_state_e          state_q [CHANNELS];
  ch_state_e          state_d [CHANNELS];
  logic [LEN_W-1:0]   cnt_q   [CHANNELS];
  logic [LEN_W-1:0]   cnt_d   [CHANNELS];

  logic [ENTRIES-1:0]  wr_sel;
  logic [ENTRIES-1:0]  tgt_idle;
  logic [ENTRIES-1:0]  hit;
  logic [ENTRIES-1:0]  fire_oh;
  logic [ENTRIES-1:0]  fired_d;
  logic                fire_any;
  logic [CH_W-1:0]     fire_chan;
  logic [LEN_W-1:0]    fire_len;
  logic                fire_mode;
  logic [CHANNELS-1:0] ch_start;

  // cfg_we is a single-cycle write strobe that is always accepted; there is no back-pressure.
  always_comb begin
    wr_sel   = '0;
    tgt_idle = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wr_sel[i] = cfg_we && (cfg_idx == IDX_W'(i));
      for (int c = 0; c < CHANNELS; c++) begin
        if (e_chan[i] == CH_W'(c) && state_q[c] == ST_IDLE) tgt_idle[i] = 1'b1;
      end
    end
  end

  // A write to an entry masks its hit in the same cycle, so the write wins.
  always_comb begin
    hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit[i] = e_valid[i] && !fired[i] && (e_addr[i] == addr) && tgt_idle[i] && !wr_sel[i];
    end
  end

  assign fire_oh  = hit & (~hit + ENTRIES'(1));
  assign fire_any = |hit;

  always_comb begin
    fire_chan = '0;
    fire_len  = '0;
    fire_mode = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (fire_oh[i]) begin
        fire_chan = e_chan[i];
        fire_len  = e_len[i];
        fire_mode = e_mode[i];
      end
    end
  end

  // Fire is applied last so it overrides both rearm and the write-clear.
  always_comb begin
    fired_d = rearm ? '0 : fired;
    fired_d = fired_d & ~wr_sel;
    fired_d = fired_d | fire_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= '0;
      fired   <= '0;
    end else begin
      fired <= fired_d;
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_sel[i]) e_valid[i] <= cfg_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_sel[i]) begin
        e_addr[i] <= cfg_addr;
        e_chan[i] <= cfg_chan;
        e_len[i]  <= cfg_len;
        e_mode[i] <= cfg_mode;
      end
    end
  end

  always_comb begin
    ch_start = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_start[c] = fire_any && (fire_chan == CH_W'(c));
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      unique case (state_q[c])
        ST_IDLE: begin
          if (ch_start[c]) begin
            state_d[c] = fire_mode ? ST_HOLD : ST_PULSE;
            cnt_d[c]   = fire_len;
          end
        end
        ST_PULSE: begin
          if (ack[c] || cnt_q[c] == '0) state_d[c] = ST_IDLE;
          else                          cnt_d[c]   = cnt_q[c] - LEN_W'(1);
        end
        ST_HOLD: begin
          if (ack[c]) state_d[c] = ST_IDLE;
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        irq[c]     <= (state_d[c] != ST_IDLE);
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    dbg_state = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      busy                = busy | (state_q[c] != ST_IDLE);
      dbg_state[2*c +: 2] = state_q[c];
    end
  end

endmodule

// File: tb/tb_itr_trigger_gen.sv
// Bench for itr_trigger_gen: directed scenarios plus a randomized run, all checked
// against a trigger-table model that tracks remaining interrupt cycles per channel.
module tb_itr_trigger_gen;
  localparam int ADDR_W   = 32;
  localparam int ENTRIES  = 16;
  localparam int CHANNELS = 6;
  localparam int LEN_W    = 8;
  localparam int IDX_W    = 4;
  localparam int CH_W     = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [ADDR_W-1:0]     addr;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [ADDR_W-1:0]     cfg_addr;
  logic [CH_W-1:0]       cfg_chan;
  logic [LEN_W-1:0]      cfg_len;
  logic                  cfg_mode;
  logic                  cfg_valid;
  logic                  rearm;
  logic [CHANNELS-1:0]   ack;
  logic [CHANNELS-1:0]   irq;
  logic [ENTRIES-1:0]    fired;
  logic                  busy;
  logic [2*CHANNELS-1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  itr_trigger_gen #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CHANNELS(CHANNELS), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_chan(cfg_chan), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .cfg_valid(cfg_valid), .rearm(rearm), .ack(ack), .irq(irq), .fired(fired),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: table contents plus cycles of irq still owed per channel
  // (0 = idle, -1 = held until ack).
  bit              m_valid [ENTRIES];
  logic [ADDR_W-1:0] m_addr [ENTRIES];
  int              m_chan  [ENTRIES];
  int              m_len   [ENTRIES];
  bit              m_hold  [ENTRIES];
  bit              m_fired [ENTRIES];
  int              m_left  [CHANNELS];

  task automatic model_edge();
    int win;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0;
        m_fired[i] = 0;
      end
      for (int c = 0; c < CHANNELS; c++) m_left[c] = 0;
      return;
    end
    win = -1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (win < 0 && m_valid[i] && !m_fired[i] && m_addr[i] == addr && m_chan[i] < CHANNELS &&
          !(cfg_we && int'(cfg_idx) == i)) begin
        if (m_left[m_chan[i]] == 0) win = i;
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (m_left[c] != 0) begin
        if (ack[c])            m_left[c] = 0;
        else if (m_left[c] > 0) m_left[c] = m_left[c] - 1;
      end
    end
    if (win >= 0) m_left[m_chan[win]] = m_hold[win] ? -1 : m_len[win] + 1;
    if (rearm) for (int i = 0; i < ENTRIES; i++) m_fired[i] = 0;
    if (cfg_we) begin
      m_valid[cfg_idx] = cfg_valid;
      m_addr[cfg_idx]  = cfg_addr;
      m_chan[cfg_idx]  = int'(cfg_chan);
      m_len[cfg_idx]   = int'(cfg_len);
      m_hold[cfg_idx]  = cfg_mode;
      m_fired[cfg_idx] = 0;
    end
    if (win >= 0) m_fired[win] = 1;
  endtask

  function automatic logic [CHANNELS-1:0] exp_irq();
    logic [CHANNELS-1:0] v;
    for (int c = 0; c < CHANNELS; c++) v[c] = (m_left[c] != 0);
    return v;
  endfunction

  function automatic logic [ENTRIES-1:0] exp_fired();
    logic [ENTRIES-1:0] v;
    for (int i = 0; i < ENTRIES; i++) v[i] = m_fired[i];
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_idx = '0; cfg_addr = '0; cfg_chan = '0; cfg_len = '0;
    cfg_mode = 0; cfg_valid = 0; rearm = 0; ack = '0;
  endtask

  task automatic program_entry(input int idx, input logic [ADDR_W-1:0] a, input int ch,
                               input int len, input bit hold);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_addr = a; cfg_chan = CH_W'(ch);
    cfg_len = LEN_W'(len); cfg_mode = hold; cfg_valid = 1;
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    addr  = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++; if (irq !== '0) begin failures++; $display("FAIL reset_irq got=%h exp=0", irq); end
    checks++; if (fired !== '0) begin failures++; $display("FAIL reset_fired got=%h exp=0", fired); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dbg_state !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", dbg_state); end
  endtask

  task automatic test_pulse();
    int hi;
    addr = '0;
    program_entry(0, 32'h308c, 2, 5, 0);
    addr = 32'h308c;
    tick();
    addr = '0;
    checks++; if (irq[2] !== 1'b1) begin failures++; $display("FAIL pulse_rise got=%b exp=1", irq[2]); end
    checks++; if (fired[0] !== 1'b1) begin failures++; $display("FAIL pulse_fired got=%b exp=1", fired[0]); end
    hi = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      hi += int'(irq[2]);
      checks++;
      if (irq !== exp_irq()) begin failures++; $display("FAIL pulse_irq k=%0d got=%h exp=%h", k, irq, exp_irq()); end
    end
    checks++; if (hi != 6) begin failures++; $display("FAIL pulse_len got=%0d exp=6", hi); end
    addr = 32'h308c;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (irq !== 6'b0) begin failures++; $display("FAIL pulse_revisit k=%0d got=%h exp=0", k, irq); end
    end
    addr = '0;
  endtask

  task automatic test_hold();
    addr = '0;
    program_entry(3, 32'h30c0, 0, 0, 1);
    addr = 32'h30c0;
    tick();
    addr = '0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (irq !== 6'b000001 || irq !== exp_irq()) begin
        failures++; $display("FAIL hold_level k=%0d got=%h exp=01", k, irq);
      end
      ack = (k == 5) ? 6'b000010 : 6'b0;
      tick();
    end
    ack = 6'b000001;
    tick();
    ack = '0;
    checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL hold_ack got=%b exp=0", irq[0]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got=%b exp=0", busy); end
  endtask

  task automatic test_arbitration();
    int r1, r4;
    addr = '0;
    program_entry(1, 32'h3100, 1, 3, 0);
    program_entry(2, 32'h3100, 4, 3, 0);
    r1 = -1; r4 = -1;
    addr = 32'h3100;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (irq[1] && r1 < 0) r1 = t;
      if (irq[4] && r4 < 0) r4 = t;
    end
    addr = '0;
    checks++; if (r1 != 0) begin failures++; $display("FAIL arb_rise1 got=%0d exp=0", r1); end
    checks++; if (r4 != 1) begin failures++; $display("FAIL arb_rise4 got=%0d exp=1", r4); end
    checks++; if (fired[2:1] !== 2'b11) begin failures++; $display("FAIL arb_fired got=%b exp=11", fired[2:1]); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (irq !== exp_irq()) begin failures++; $display("FAIL arb_irq k=%0d got=%h exp=%h", k, irq, exp_irq()); end
    end
  endtask

  task automatic test_blocked();
    logic [11:0] trace;
    addr = '0;
    program_entry(6, 32'h4000, 2, 3, 0);
    program_entry(5, 32'h4100, 2, 1, 0);
    addr = 32'h4000;
    tick();
    trace[0] = irq[2];
    addr = 32'h4100;
    for (int k = 1; k < 12; k++) begin
      tick();
      trace[k] = irq[2];
      if (k == 3) begin
        checks++;
        if (fired[5] !== 1'b0) begin failures++; $display("FAIL blocked_nofire got=%b exp=0", fired[5]); end
      end
      if (k == 5) begin
        checks++;
        if (fired[5] !== 1'b1) begin failures++; $display("FAIL blocked_retry got=%b exp=1", fired[5]); end
      end
    end
    addr = '0;
    checks++; if (trace !== 12'h06F) begin failures++; $display("FAIL blocked_trace got=%h exp=06f", trace); end
  endtask

  task automatic test_write_wins();
    int hi;
    addr  = '0;
    rearm = 1;
    tick();
    rearm = 0;
    checks++; if (fired !== '0) begin failures++; $display("FAIL rearm_clear got=%h exp=0", fired); end
    addr = 32'h308c;
    program_entry(0, 32'h5000, 2, 0, 0);
    addr = '0;
    checks++; if (irq !== 6'b0) begin failures++; $display("FAIL write_wins_irq got=%h exp=0", irq); end
    checks++; if (fired[0] !== 1'b0) begin failures++; $display("FAIL write_wins_fired got=%b exp=0", fired[0]); end
    rearm = 1;
    tick();
    rearm = 0;
    addr = 32'h5000;
    tick();
    addr = '0;
    checks++; if (irq[2] !== 1'b1) begin failures++; $display("FAIL len0_rise got=%b exp=1", irq[2]); end
    tick();
    checks++; if (irq[2] !== 1'b0) begin failures++; $display("FAIL len0_fall got=%b exp=0", irq[2]); end
    program_entry(0, 32'h5000, 2, 255, 0);
    addr = 32'h5000;
    tick();
    addr = '0;
    hi = int'(irq[2]);
    for (int k = 0; k < 259; k++) begin
      tick();
      hi += int'(irq[2]);
      checks++;
      if (irq !== exp_irq()) begin failures++; $display("FAIL len255_irq k=%0d got=%h exp=%h", k, irq, exp_irq()); end
    end
    checks++; if (hi != 256) begin failures++; $display("FAIL len255_len got=%0d exp=256", hi); end
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] olds [6];
    olds = '{32'h30c0, 32'h5000, 32'h308c, 32'h3100, 32'h4000, 32'h4100};
    addr  = '0;
    rearm = 1;
    tick();
    rearm = 0;
    addr = 32'h30c0; tick();
    addr = 32'h5000; tick();
    addr = '0;       tick();
    checks++; if (irq !== 6'b000101) begin failures++; $display("FAIL mid_active got=%h exp=05", irq); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (irq !== '0 || fired !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset got irq=%h fired=%h busy=%b exp=0", irq, fired, busy);
    end
    for (int k = 0; k < 6; k++) begin
      addr = olds[k];
      tick();
      checks++;
      if (irq !== '0 || fired !== '0) begin
        failures++; $display("FAIL mid_revisit k=%0d got irq=%h fired=%h exp=0", k, irq, fired);
      end
    end
    addr = '0;
    program_entry(3, 32'h30c0, 0, 0, 1);
    addr = 32'h30c0;
    tick();
    addr = '0;
    checks++; if (irq !== 6'b000001) begin failures++; $display("FAIL mid_reprog got=%h exp=01", irq); end
    ack = 6'b000001;
    tick();
    ack = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 399) == 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_idx   = IDX_W'($urandom_range(0, ENTRIES - 1));
      cfg_addr  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      cfg_chan  = CH_W'($urandom_range(0, 7));
      cfg_len   = LEN_W'($urandom_range(0, 15));
      cfg_mode  = 1'($urandom_range(0, 1));
      cfg_valid = ($urandom_range(0, 3) != 0);
      rearm     = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < CHANNELS; c++) ack[c] = ($urandom_range(0, 7) == 0);
      addr      = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      tick();
      checks++;
      if (irq !== exp_irq()) begin failures++; $display("FAIL rand_irq n=%0d got=%h exp=%h", n, irq, exp_irq()); end
      checks++;
      if (fired !== exp_fired()) begin failures++; $display("FAIL rand_fired n=%0d got=%h exp=%h", n, fired, exp_fired()); end
      checks++;
      if (busy !== (|exp_irq())) begin failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, |exp_irq()); end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_pulse();
    test_hold();
    test_arbitration();
    test_blocked();
    test_write_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/itr_trigger_gen.md
# itr_trigger_gen

Address-triggered interrupt stimulus generator for the CPU interrupt test environment. It watches the core's monitored address bus and compares it against a programmable table of trigger entries. Each entry fires once, raising one of several interrupt lines either as a fixed-length pulse or as a level held until acknowledged. It generalises the fixed single-line, fixed-length interrupt injector: entry count, channel count and pulse-counter width are parameters, and each entry carries its own channel and mode.

## Interface
- ADDR_W, 32, width of monitored address and entry address
- ENTRIES, 16, number of trigger-table entries (≥1)
- CHANNELS, 6, number of interrupt output lines (≥1)
- LEN_W, 8, width of pulse-length field
- IDX_W, $clog2(ENTRIES) (min 1), entry index width (derived)
- CH_W, $clog2(CHANNELS) (min 1), channel index width (derived)

- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- addr  in  ADDR_W  monitored address (core PC/macroscopic address)
- cfg_we  in  1  write one table entry this cycle
- cfg_idx  in  IDX_W  entry being written
- cfg_addr  in  ADDR_W  trigger address
- cfg_chan  in  CH_W  target interrupt channel
- cfg_len  in  LEN_W  pulse length minus one
- cfg_mode  in  1  0 = pulse, 1 = hold until ack
- cfg_valid  in  1  entry enable
- rearm  in  1  clear all fired flags
- ack  in  CHANNELS  per-channel interrupt acknowledge
- irq  out  CHANNELS  interrupt lines, registered
- fired  out  ENTRIES  per-entry fired flags, registered
- busy  out  1  OR of all channels not IDLE, combinational from state regs

## Operation
- Entry state: valid, addr, chan, len, mode, fired. Reset clears valid and fired. Other fields are don't-care.
- Match: entry i hits when valid[i] && !fired[i] && addr == entry.addr && the channel FSM of entry.chan is IDLE.
- Arbitration: the lowest-index hitting entry is taken; at most one entry fires per cycle. Entries that are blocked (target channel busy) or lose arbitration are not marked fired and retry every cycle while addr still matches.
- Firing entry i sets fired[i] and starts the FSM of channel entry.chan.
- Per-channel FSM states: IDLE, PULSE, HOLD.
  - IDLE → PULSE (mode 0): load cnt = len, irq = 1.
  - IDLE → HOLD (mode 1): irq = 1.
  - PULSE: if ack[c] or cnt == 0 → IDLE, irq = 0. Otherwise decrement cnt.
  - HOLD: ack[c] → IDLE, irq = 0. Otherwise stay.
- ack on an IDLE channel is ignored.
- cfg_we writes all fields of cfg_idx and clears its fired flag. If a write and a hit target the same entry in the same cycle, the write wins: the entry does not fire and the new contents apply from the next cycle. A write to an entry whose interrupt is in progress does not disturb the running channel FSM.
- rearm clears every fired flag. If rearm coincides with a firing, the firing entry's fired bit ends set (fire wins over rearm for that entry).
- Reset mid-operation: all FSMs return to IDLE, irq = 0, table invalidated, and any counter is discarded.

## Timing
- Reset values: irq = 0, fired = 0, busy = 0, all FSMs IDLE.
- addr is sampled at rising edge N; irq[c] is high after edge N (visible in cycle N+1).
- Pulse mode: irq high for exactly len+1 cycles. len = 0 gives 1 cycle; len = 2^LEN_W−1 gives 2^LEN_W cycles.
- Early ack in PULSE or HOLD: irq falls after the edge at which ack is sampled.
- Back-to-back: once a channel returns to IDLE at edge M, a new hit can be sampled at edge M+1. The minimum low gap between irq pulses on one channel is therefore 1 cycle.
- Independent channels may fire on consecutive cycles. Simultaneous hits on different channels are serialised one per cycle by index priority.
- fired[i] updates on the same edge that raises irq.

## Test plan
- Reset, then program entry 0 = {0x308c, ch 2, len 5, pulse} → addr = 0x308c at edge N gives irq[2] high in cycles N+1..N+6, then low; fired[0] = 1; a second visit to 0x308c gives no pulse.
- Entry 3 = {0x30c0, ch 0, hold} → irq[0] stays high 20 cycles until ack[0] is pulsed, then falls the next cycle; ack[1] while IDLE has no effect.
- Entries 1 and 2 both at 0x3100, ch 1 and ch 4, addr held 3 cycles → entry 1 fires at the first edge and entry 2 at the second; irq[1] and irq[4] rise one cycle apart.
- Entry 5 targets ch 2 while ch 2 is in PULSE → entry 5 is not fired; with addr held, it fires the cycle after ch 2 returns to IDLE.
- cfg_we to entry 0 at the same edge as its hit → no irq. Then rearm and revisit the new address → it fires. len = 0 gives a 1-cycle pulse; len = 255 gives 256 cycles.
- Assert reset during a HOLD and a PULSE → irq = 0, fired = 0, busy = 0 next cycle; revisiting old addresses gives no irq until the table is reprogrammed.
